// File: rtl/traffic_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : traffic_input_cond
// Brief    : Synchronizes and debounces the walk button and side-road sensor,
//            latches pedestrian requests and generates the timing tick.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_input_cond #(
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic rst,
    input  logic walk_btn,
    input  logic sensor_raw,
    input  logic walk_ack,
    input  logic tick_sync,
    output logic walk,
    output logic sensor,
    output logic tick
);

    localparam int c_DB_W   = $clog2(DB_CYCLES + 1);
    localparam int c_TICK_W = $clog2(TICK_DIV);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);

    // Bit 0 carries the walk button, bit 1 the sensor.
    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {sensor_raw, walk_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic              r_sync1;
            logic              r_sync2;
            logic              r_deb;
            logic [c_DB_W-1:0] r_cnt;

            // The counter only advances while s2 disagrees with deb and is
            // cleared on acceptance, so it never exceeds DB_CYCLES-1.
            always_ff @(posedge clock or negedge rst) begin
                if (!rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DB_ONE;
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    logic r_walk_deb_q;
    logic r_walk;
    logic w_press;

    assign w_press = w_deb[0] & ~r_walk_deb_q;

    // A fresh press takes priority over an acknowledge in the same cycle.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_walk_deb_q <= 1'b0;
            r_walk       <= 1'b0;
        end else begin
            r_walk_deb_q <= w_deb[0];
            if (w_press) begin
                r_walk <= 1'b1;
            end else if (walk_ack) begin
                r_walk <= 1'b0;
            end
        end
    end

    logic [c_TICK_W-1:0] r_tick_cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (tick_sync || (r_tick_cnt == c_TICK_LAST)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    assign walk   = r_walk;
    assign sensor = w_deb[1];
    assign tick   = (r_tick_cnt == c_TICK_LAST);

endmodule
`default_nettype wire

// File: tb/tb_traffic_input_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_input_cond
// Brief    : Scoreboard bench for traffic_input_cond (TICK_DIV=10, DB_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_input_cond;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;

    localparam logic [2:0] M_W   = 3'b100;
    localparam logic [2:0] M_S   = 3'b010;
    localparam logic [2:0] M_T   = 3'b001;
    localparam logic [2:0] M_ALL = 3'b111;

    logic clock      = 1'b0;
    logic rst        = 1'b0;
    logic walk_btn   = 1'b0;
    logic sensor_raw = 1'b0;
    logic walk_ack   = 1'b0;
    logic tick_sync  = 1'b0;
    logic walk;
    logic sensor;
    logic tick;

    int n_checks = 0;
    int n_fail   = 0;

    // One entry per clock: inputs driven before the edge, outputs expected after it.
    typedef struct {
        logic       btn;
        logic       sraw;
        logic       ack;
        logic       tsync;
        logic [2:0] mask;
        logic [2:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    traffic_input_cond #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .walk_btn   (walk_btn),
        .sensor_raw (sensor_raw),
        .walk_ack   (walk_ack),
        .tick_sync  (tick_sync),
        .walk       (walk),
        .sensor     (sensor),
        .tick       (tick)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push(input logic btn, input logic sraw, input logic ack, input logic tsync,
                        input logic [2:0] mask, input logic [2:0] val, input string tag);
        exp_t e;
        e.btn = btn; e.sraw = sraw; e.ack = ack; e.tsync = tsync;
        e.mask = mask; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [2:0] obs;
        for (int k = 0; k < 6; k++) push(1'b1, 1'b1, 1'b0, 1'b0, M_ALL, 3'b000, "reset_hold_active");
        for (int k = 0; k < 2; k++) push(1'b0, 1'b0, 1'b0, 1'b0, M_ALL, 3'b000, "reset_hold_idle");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_tick();
        exp_t e;
        logic [2:0] obs;
        rst = 1'b1;
        // Tick seen right after edge k is what edge k+1 samples: edges 10, 20, 30.
        for (int k = 1; k <= 35; k++)
            push(1'b0, 1'b0, 1'b0, 1'b0, M_ALL, {2'b00, ((k + 1) % TICK_DIV == 0)}, "tick_period");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_tick_sync();
        exp_t e;
        logic [2:0] obs;
        push(1'b0, 1'b0, 1'b0, 1'b1, M_T, 3'b000, "tick_sync_load");
        for (int j = 1; j <= 24; j++)
            push(1'b0, 1'b0, 1'b0, 1'b0, M_T, {2'b00, (j == 9 || j == 19)}, "tick_after_sync");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_sensor();
        exp_t e;
        logic [2:0] obs;
        for (int k = 1; k <= 10; k++) push(1'b0, 1'b1, 1'b0, 1'b0, M_S, {1'b0, (k >= 6), 1'b0}, "sensor_rise");
        for (int k = 1; k <= 3; k++)  push(1'b0, 1'b0, 1'b0, 1'b0, M_S, 3'b010, "sensor_glitch");
        for (int k = 1; k <= 8; k++)  push(1'b0, 1'b1, 1'b0, 1'b0, M_S, 3'b010, "sensor_hold");
        for (int k = 1; k <= 8; k++)  push(1'b0, 1'b0, 1'b0, 1'b0, M_S, {1'b0, (k < 6), 1'b0}, "sensor_fall");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_walk_bounce();
        exp_t e;
        logic [2:0] obs;
        push(1'b0, 1'b0, 1'b1, 1'b0, M_W, 3'b000, "ack_while_idle");
        for (int c = 0; c < 20; c++) push(((c / 2) % 2 == 0), 1'b0, 1'b0, 1'b0, M_W, 3'b000, "walk_bounce");
        for (int k = 1; k <= 10; k++) push(1'b1, 1'b0, 1'b0, 1'b0, M_W, {(k >= 7), 2'b00}, "walk_press");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_walk_ack();
        exp_t e;
        logic [2:0] obs;
        push(1'b1, 1'b0, 1'b1, 1'b0, M_W, 3'b000, "ack_clears");
        for (int k = 1; k <= 8; k++)  push(1'b1, 1'b0, 1'b0, 1'b0, M_W, 3'b000, "held_no_reset");
        for (int k = 1; k <= 8; k++)  push(1'b0, 1'b0, 1'b0, 1'b0, M_W, 3'b000, "release");
        for (int k = 1; k <= 10; k++) push(1'b1, 1'b0, 1'b0, 1'b0, M_W, {(k >= 7), 2'b00}, "repress");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_press_ack_same();
        exp_t e;
        logic [2:0] obs;
        for (int k = 1; k <= 8; k++) push(1'b0, 1'b0, 1'b0, 1'b0, M_W, 3'b100, "latch_holds");
        for (int k = 1; k <= 6; k++) push(1'b1, 1'b0, 1'b0, 1'b0, M_W, 3'b100, "press_pending");
        // Press event is live in the cycle after deb rises (edge 6), same as this ack.
        push(1'b1, 1'b0, 1'b1, 1'b0, M_W, 3'b100, "press_beats_ack");
        for (int k = 1; k <= 3; k++) push(1'b1, 1'b0, 1'b0, 1'b0, M_W, 3'b100, "after_collision");
        push(1'b1, 1'b0, 1'b1, 1'b0, M_W, 3'b000, "ack_after_collision");
        for (int k = 1; k <= 2; k++) push(1'b1, 1'b0, 1'b0, 1'b0, M_W, 3'b000, "stays_clear");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [2:0] obs;
        for (int k = 1; k <= 8; k++) push(1'b0, 1'b0, 1'b0, 1'b0, M_W, 3'b000, "pre_release");
        for (int k = 1; k <= 8; k++) push(1'b1, 1'b1, 1'b0, 1'b0, M_W | M_S, {(k >= 7), (k >= 6), 1'b0}, "arm_outputs");
        push(1'b1, 1'b1, 1'b0, 1'b1, M_W | M_S, 3'b110, "arm_sync");
        for (int j = 1; j <= 7; j++) push(1'b1, 1'b1, 1'b0, 1'b0, M_ALL, 3'b110, "count_to_7");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end

        // Reset pulse between edges; no clock edge occurs while it is low.
        rst = 1'b0; walk_btn = 1'b0; sensor_raw = 1'b0;
        #1;
        obs = {walk, sensor, tick};
        n_checks++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: {walk,sensor,tick}=%b expected 000", obs);
        end
        #2;
        rst = 1'b1;
        obs = {walk, sensor, tick};
        n_checks++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL after_release: {walk,sensor,tick}=%b expected 000", obs);
        end

        for (int k = 1; k <= 12; k++)
            push(1'b0, 1'b0, 1'b0, 1'b0, M_ALL, {2'b00, (k + 1 == TICK_DIV)}, "tick_after_reset");
        while (sb.size() > 0) begin
            e = sb.pop_front();
            walk_btn = e.btn; sensor_raw = e.sraw; walk_ack = e.ack; tick_sync = e.tsync;
            step();
            obs = {walk, sensor, tick};
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL %s: {walk,sensor,tick}=%b expected %b mask %b", e.tag, obs, e.val, e.mask);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (3) step();
        test_reset();
        test_tick();
        test_tick_sync();
        test_sensor();
        test_walk_bounce();
        test_walk_ack();
        test_press_ack_same();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
